// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, a single-entry output buffer, and redirect squash.
// Optional FETCH_STALL_CNT_EN adds stall_cnt/squash_cnt performance counters.

`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif

module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDR_WIDTH-1:0]    imem_addr,
  input  logic                     imem_ready,
  input  logic                     imem_rvalid,
  input  logic [`INST_WIDTH-1:0]   imem_rdata,
  input  logic                     redirect_valid,
  input  logic [ADDR_WIDTH-1:0]    redirect_pc,
  output logic                     inst_valid,
  input  logic                     id_ready,
  output logic [`INST_WIDTH-1:0]   inst,
  output logic [`OPCODE_WIDTH-1:0] opcode,
  output logic [ADDR_WIDTH-1:0]    inst_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [15:0]              squash_cnt
`endif
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic                  unused_bits;

  assign unused_bits = ^redirect_pc[1:0];
  assign imem_req    = (state == FETCH) && !rst;
  assign imem_addr   = pc_q;

  // Redirect overrides every state; the next state depends on whether a request is still owed a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc_q       <= RESET_PC;
      req_pc     <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      opcode     <= '0;
      inst_pc    <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q       <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      inst_valid <= 1'b0;
      case (state)
        FETCH:   state <= imem_ready  ? DRAIN : FETCH;
        WAIT:    state <= imem_rvalid ? FETCH : DRAIN;
        HOLD:    state <= FETCH;
        DRAIN:   state <= imem_rvalid ? FETCH : DRAIN;
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            req_pc <= pc_q;
            pc_q   <= pc_q + PC_STEP;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            inst       <= imem_rdata;
            opcode     <= imem_rdata[`OPCODE_WIDTH-1:0];
            inst_pc    <= req_pc;
            inst_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (id_ready) begin
            inst_valid <= 1'b0;
            state      <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_rvalid) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_STALL_CNT_EN
  // A squash is counted only when a buffered or in-flight instruction is actually lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (inst_valid && !id_ready) stall_cnt <= stall_cnt + 32'd1;
      if (redirect_valid && (state == HOLD || state == WAIT || (state == FETCH && imem_ready)))
        squash_cnt <= squash_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected instructions into a scoreboard that a monitor drains.
// Counter checks are compiled in when FETCH_STALL_CNT_EN is defined.

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [6:0]  op;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        id_ready = 1'b1;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [31:0] inst_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [15:0] squash_cnt;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .id_ready(id_ready),
    .inst(inst), .opcode(opcode), .inst_pc(inst_pc)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Waits (bounded) for a request, accepts it, returns the word one cycle later.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] word,
                               input logic [6:0] op, input bit deliver, output int waits);
    waits = 0;
    while (!imem_req && waits < 20) begin
      step();
      waits++;
    end
    checkOutput("imem_req_seen", {31'b0, imem_req}, 32'd1);
    checkOutput("imem_addr", imem_addr, addr);
    imem_ready = 1'b1;
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    if (deliver) sb.push_back('{addr, word, op});
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
  endtask

  initial begin
    int waits;
    logic [31:0] words[3];
    logic [6:0]  ops[3];
    words[0] = 32'h0010_0093; ops[0] = 7'h13;
    words[1] = 32'h0020_8133; ops[1] = 7'h33;
    words[2] = 32'h0000_006F; ops[2] = 7'h6F;

    // Monitor: every accepted handshake must match the head of the scoreboard.
    fork
      forever begin
        @(negedge clk);
        if (!rst && inst_valid && id_ready && !redirect_valid) begin
          if (sb.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_inst: got pc %h inst %h expected none", inst_pc, inst);
          end else begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (inst === e.word && opcode === e.op && inst_pc === e.pc) passed++;
            else $display("[TB] FAIL inst_handshake: got pc %h inst %h op %h expected pc %h inst %h op %h",
                          inst_pc, inst, opcode, e.pc, e.word, e.op);
          end
        end
      end
    join_none

    #1 rst = 1'b1;
    step();
    checkOutput("rst_imem_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst_inst", inst, 32'd0);
    checkOutput("rst_opcode", {25'b0, opcode}, 32'd0);
    checkOutput("rst_inst_pc", inst_pc, RESET_PC);
    step();
    rst = 1'b0;

    $display("[TB] sequential fetch from reset PC");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h100 + 32'(4 * i), words[i], ops[i], 1'b1, waits);
      if (i > 0) checkOutput("fetch_gap", 32'(waits), 32'd1);
      checkOutput("valid_latency", {31'b0, inst_valid}, 32'd1);
      checkOutput("no_req_in_hold", {31'b0, imem_req}, 32'd0);
    end
    step();

    $display("[TB] decode stall in HOLD");
    id_ready = 1'b0;
    applyStimulus(32'h10C, 32'h0050_0093, 7'h13, 1'b1, waits);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_inst", inst, 32'h0050_0093);
      checkOutput("stall_opcode", {25'b0, opcode}, 32'h13);
      checkOutput("stall_inst_pc", inst_pc, 32'h10C);
      checkOutput("stall_no_req", {31'b0, imem_req}, 32'd0);
      step();
    end
`ifdef FETCH_STALL_CNT_EN
    checkOutput("stall_cnt", stall_cnt, 32'd5);
`endif
    id_ready = 1'b1;
    step();

    $display("[TB] redirect while WAIT");
    checkOutput("pre_redirect_addr", imem_addr, 32'h110);
    imem_ready = 1'b1;
    step();
    imem_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    step();
    redirect_valid = 1'b0;
    checkOutput("drain_no_req", {31'b0, imem_req}, 32'd0);
    checkOutput("drain_valid", {31'b0, inst_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBADB_AD13;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    checkOutput("post_drain_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("post_drain_req", {31'b0, imem_req}, 32'd1);
`ifdef FETCH_STALL_CNT_EN
    checkOutput("squash_wait", {16'b0, squash_cnt}, 32'd1);
`endif
    applyStimulus(32'h200, 32'h1234_50B7, 7'h37, 1'b1, waits);
    step();

    $display("[TB] redirect in HOLD with id_ready");
    applyStimulus(32'h204, 32'h00A0_0513, 7'h13, 1'b0, waits);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();
    redirect_valid = 1'b0;
    checkOutput("hold_redirect_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("hold_redirect_req", {31'b0, imem_req}, 32'd1);
    checkOutput("hold_redirect_addr", imem_addr, 32'h300);
`ifdef FETCH_STALL_CNT_EN
    checkOutput("squash_hold", {16'b0, squash_cnt}, 32'd2);
`endif

    $display("[TB] PC wrap");
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    checkOutput("redirect_align", imem_addr, 32'hFFFF_FFFC);
`ifdef FETCH_STALL_CNT_EN
    checkOutput("squash_idle_fetch", {16'b0, squash_cnt}, 32'd2);
`endif
    applyStimulus(32'hFFFF_FFFC, 32'h0000_0073, 7'h73, 1'b1, waits);
    step();
    applyStimulus(32'h0, 32'hFE01_0113, 7'h13, 1'b1, waits);
    step();

    $display("[TB] reset during WAIT");
    checkOutput("pre_reset_addr", imem_addr, 32'h4);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("mid_rst_inst", inst, 32'd0);
    checkOutput("mid_rst_opcode", {25'b0, opcode}, 32'd0);
    checkOutput("mid_rst_inst_pc", inst_pc, RESET_PC);
`ifdef FETCH_STALL_CNT_EN
    checkOutput("mid_rst_stall_cnt", stall_cnt, 32'd0);
    checkOutput("mid_rst_squash_cnt", {16'b0, squash_cnt}, 32'd0);
`endif
    step();
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    checkOutput("post_rst_addr", imem_addr, RESET_PC);
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    checkOutput("late_rvalid_ignored", {31'b0, inst_valid}, 32'd0);
    checkOutput("late_rvalid_req", {31'b0, imem_req}, 32'd1);
    applyStimulus(RESET_PC, 32'h0640_0593, 7'h13, 1'b1, waits);
    step();
    step();

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
